// File: rtl/mlaccel_memory_reader_if.sv
// Bus bundle for the memory reader: command channel, memory port and output stream.
// The master view belongs to the reader; the slave view belongs to its environment.
interface mlaccel_memory_reader_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_stride;
   logic [15:0] cmd_count;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wen;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;

   modport master (
      input  cmd_valid, cmd_addr, cmd_stride, cmd_count,
      output cmd_ready,
      output mem_addr, mem_wen, mem_wdata,
      input  mem_rdata,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_stride, cmd_count,
      input  cmd_ready,
      input  mem_addr, mem_wen, mem_wdata,
      output mem_rdata,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/mlaccel_memory_reader.sv
// Strided burst reader for the 64-bit memory port; returned words are streamed
// through a small FIFO whose free space is reserved before each read is issued.
module mlaccel_memory_reader #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   mlaccel_memory_reader_if.master bus,
   output logic                    busy,
   output logic                    done
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = CW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state, next_state;

   logic [15:0]   cur_addr;
   logic [15:0]   stride;
   logic [15:0]   remaining;
   logic [15:0]   addr_hold;
   logic          rd_pending;
   logic          pending_last;
   logic [63:0]   fifo_data [FIFO_DEPTH];
   logic          fifo_last [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [OW-1:0] occupancy;
   logic          cmd_fire;
   logic          pop;
   logic          push;
   logic          credit_ok;
   logic          issue;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
   assign pop      = bus.out_valid & bus.out_ready;
   assign push     = rd_pending;

   // Memory data cannot be stalled, so a read may only go out if its word is
   // guaranteed a slot: count what is stored plus what is in flight, less this pop.
   assign occupancy = OW'(fifo_count) + OW'(rd_pending) - OW'(pop);
   assign credit_ok = occupancy < OW'(FIFO_DEPTH);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cmd_fire) begin
               next_state = (bus.cmd_count != 16'd0) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if (issue && (remaining == 16'd1)) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (!rd_pending && ((fifo_count == CW'(0)) ||
                                ((fifo_count == CW'(1)) && pop))) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state == IDLE);
      busy          = (state != IDLE);
      done          = (state == DONE);
      issue         = (state == ISSUE) && (remaining != 16'd0) && credit_ok;
      bus.mem_addr  = issue ? cur_addr : addr_hold;
   end

   assign bus.mem_wen   = '0;
   assign bus.mem_wdata = '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_addr     <= '0;
         stride       <= '0;
         remaining    <= '0;
         addr_hold    <= '0;
         rd_pending   <= 1'b0;
         pending_last <= 1'b0;
      end else begin
         if (cmd_fire) begin
            cur_addr  <= bus.cmd_addr;
            stride    <= bus.cmd_stride;
            remaining <= bus.cmd_count;
         end else if (issue) begin
            cur_addr  <= cur_addr + stride;
            remaining <= remaining - 16'd1;
            addr_hold <= cur_addr;
         end
         rd_pending   <= issue;
         pending_last <= issue && (remaining == 16'd1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= bus.mem_rdata;
         fifo_last[wr_ptr] <= pending_last;
      end
   end

   assign bus.out_valid = (fifo_count != CW'(0));
   assign bus.out_data  = fifo_data[rd_ptr];
   assign bus.out_last  = bus.out_valid & fifo_last[rd_ptr];
endmodule
